// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM bus-side controller.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  // Widest word the byte-merge helper handles; callers size-cast in and out.
  localparam int unsigned MERGE_MAX_W = 1024;
  localparam int unsigned MERGE_MAX_M = MERGE_MAX_W / 8;

  // One byte-enable bit per 8-bit lane.
  function automatic int unsigned mask_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Per-byte select: enabled lanes take the new word, others keep the old word.
  function automatic logic [MERGE_MAX_W-1:0] merge_bytes(
    input logic [MERGE_MAX_W-1:0] old_word,
    input logic [MERGE_MAX_W-1:0] new_word,
    input logic [MERGE_MAX_M-1:0] mask
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < int'(MERGE_MAX_M); i++) begin
      if (mask[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Bus-side controller for a single-port RW SRAM macro. One request in flight;
// byte-masked writes are done as read-modify-write because the macro has no
// byte enables. Every SRAM pin is driven straight from a flop.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = 7,
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned MASK_W     = mask_width(DATA_WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [MASK_W-1:0]     req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  state_t state;
  state_t state_next;

  logic                  accept;
  logic                  addr_err;
  logic                  mask_full;
  logic                  mask_zero;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  csb_next;
  logic                  web_next;
  logic [DATA_WIDTH-1:0] merged;

  // Request held across RD/CAP/WR; we_q marks a partial write (RMW) in CAP.
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [MASK_W-1:0]     wmask_q;
  logic                  we_q;

  assign accept    = req_valid && (state == IDLE);
  assign addr_err  = (req_addr[1:0] != 2'b00) || (|req_addr[31:ADDR_WIDTH+2]);
  assign mask_full = &req_wmask;
  assign mask_zero = ~|req_wmask;
  assign req_idx   = req_addr[ADDR_WIDTH+1:2];
  assign merged    = DATA_WIDTH'(merge_bytes(MERGE_MAX_W'(sram_dout0),
                                             MERGE_MAX_W'(wdata_q),
                                             MERGE_MAX_M'(wmask_q)));

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; errors and empty-mask writes skip the SRAM entirely.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (addr_err)       state_next = RESP;
          else if (!req_we)   state_next = RD;
          else if (mask_zero) state_next = RESP;
          else if (mask_full) state_next = WR;
          else                state_next = RD;
        end
      end
      RD:      state_next = CAP;
      CAP:     state_next = we_q ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs plus next values for the registered SRAM strobes.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    csb_next  = !((state_next == RD) || (state_next == WR));
    web_next  = !(state_next == WR);
  end

  // SRAM pins and response fields; all reset to their idle values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      sram_csb0 <= csb_next;
      sram_web0 <= web_next;
      if (accept) begin
        rsp_rdata <= '0;
        rsp_err   <= addr_err;
        if (!addr_err) begin
          sram_addr0 <= req_idx;
          sram_din0  <= req_wdata;
        end
      end
      if (state == CAP) begin
        if (we_q) begin
          sram_din0 <= merged;
        end else begin
          rsp_rdata <= sram_dout0;
        end
      end
    end
  end

  // Request capture; contents only matter after an accept, so no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
      we_q    <= req_we;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl with a behavioural SRAM macro and a response scoreboard.
module tb_sram_ctrl;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [DW-1:0] req_wdata;
  logic [MW-1:0] req_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          sram_csb0;
  logic          sram_web0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0;

  initial forever #5 clock = ~clock;

  sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  // Behavioural single-port SRAM with an access log.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            n_rd = 0;
  int            n_wr = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [DW-1:0] last_wr_data = '0;
  logic [7:0]    seq = '0;

  always @(posedge clock) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        mem[sram_addr0] <= sram_din0;
        n_wr            <= n_wr + 1;
        last_wr_addr    <= sram_addr0;
        last_wr_data    <= sram_din0;
        seq             <= {seq[6:0], 1'b0};
      end else begin
        sram_dout0 <= mem[sram_addr0];
        n_rd       <= n_rd + 1;
        seq        <= {seq[6:0], 1'b1};
      end
    end
  end

  typedef struct {
    logic          we;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_acc;
    int            exp_lat;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  vec_t          vecs [8];
  exp_t          exp_q [$];
  logic [DW-1:0] refm [0:7];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            rdy_mode = 1;
  int            viol = 0;
  logic          prev_csb_low = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [DW-1:0] tb_merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                             input logic [MW-1:0] m);
    logic [DW-1:0] r;
    for (int b = 0; b < MW; b++) r[8*b +: 8] = m[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction

  // One clock: observe at the falling edge, then drive rsp_ready after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    if (!sram_csb0 && prev_csb_low) viol++;
    if (rsp_valid && !sram_csb0) viol++;
    prev_csb_low = !sram_csb0;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got rdata %0h err %0b with no request pending", rsp_rdata, rsp_err);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
    @(posedge clock);
    cyc++;
    #1;
    case (rdy_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [DW-1:0] wdata,
                       input logic [MW-1:0] wmask, input logic [DW-1:0] exp_rdata,
                       input logic exp_err, input bit push);
    int   n = 0;
    exp_t e;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: req_ready still %0b after %0d cycles, need 1", req_ready, n);
    end else if (push) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      exp_q.push_back(e);
    end
    tick();
    req_valid = 1'b0;
  endtask

  // Edges from the accept edge (counted as 1) until rsp_valid is seen.
  task automatic measure_lat(input string name, input int exp_lat);
    int n = 1;
    while (!rsp_valid && n < 30) begin
      tick();
      n++;
    end
    check(name, 64'(n), 64'(exp_lat));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || !req_ready) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: pending=%0d req_ready=%0b, need 0 and 1", exp_q.size(), req_ready);
    end
  endtask

  initial begin
    int            a_rd;
    int            a_wr;
    int            a_acc;
    logic [DW-1:0] snap;
    int            n;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, 1, 2};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 1, 3};
    vecs[2] = '{1'b0, 32'h0000_0202, 32'h0,         4'h0, 32'h0,         1'b1, 0, 1};
    vecs[3] = '{1'b0, 32'h0000_0200, 32'h0,         4'h0, 32'h0,         1'b1, 0, 1};
    vecs[4] = '{1'b1, 32'h0000_0020, 32'h5555_5555, 4'h0, 32'h0,         1'b0, 0, 1};
    vecs[5] = '{1'b1, 32'h0000_01FC, 32'h0BAD_F00D, 4'hF, 32'h0,         1'b0, 1, 2};
    vecs[6] = '{1'b0, 32'h0000_01FC, 32'h0,         4'h0, 32'h0BAD_F00D, 1'b0, 1, 3};
    vecs[7] = '{1'b1, 32'h0000_0003, 32'h1234_5678, 4'hF, 32'h0,         1'b1, 0, 1};

    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    rsp_ready = 1'b0;
    reset_n   = 1'b1;
    #2;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_csb0", 64'(sram_csb0), 64'(1));
    check("reset_web0", 64'(sram_web0), 64'(1));
    check("reset_addr0", 64'(sram_addr0), 64'(0));
    check("reset_din0", 64'(sram_din0), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("reset_rsp_err", 64'(rsp_err), 64'(0));
    check("reset_req_ready", 64'(req_ready), 64'(1));
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    rdy_mode  = 1;

    // Table: full write / read, errors, empty-mask write, last word of the array.
    for (int i = 0; i < 8; i++) begin
      a_acc = n_rd + n_wr;
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
            vecs[i].exp_rdata, vecs[i].exp_err, 1'b1);
      measure_lat($sformatf("latency_v%0d", i), vecs[i].exp_lat);
      wait_idle();
      check($sformatf("sram_accesses_v%0d", i), 64'(n_rd + n_wr - a_acc), 64'(vecs[i].exp_acc));
      if (vecs[i].we && vecs[i].exp_acc != 0) begin
        check($sformatf("wr_addr_v%0d", i), 64'(last_wr_addr), 64'(vecs[i].addr[AW+1:2]));
        check($sformatf("wr_data_v%0d", i), 64'(last_wr_data), 64'(vecs[i].wdata));
      end
    end

    // Response held under back-pressure; requests during RESP are ignored.
    rdy_mode = 0;
    tick();
    a_rd = n_rd;
    a_wr = n_wr;
    issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_rsp_valid_seen", 64'(rsp_valid), 64'(1));
    snap = rsp_rdata;
    check("bp_rdata_value", 64'(snap), 64'(32'hDEAD_BEEF));
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        req_wmask = 4'hF;
        req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      check($sformatf("bp_valid_%0d", i), 64'(rsp_valid), 64'(1));
      check($sformatf("bp_rdata_%0d", i), 64'(rsp_rdata), 64'(snap));
      check($sformatf("bp_req_ready_%0d", i), 64'(req_ready), 64'(0));
      tick();
    end
    req_valid = 1'b0;
    rdy_mode  = 1;
    wait_idle();
    tick();
    tick();
    check("bp_no_phantom_rsp", 64'(rsp_valid), 64'(0));
    check("bp_reads", 64'(n_rd - a_rd), 64'(1));
    check("bp_writes", 64'(n_wr - a_wr), 64'(0));

    // Read-modify-write with a sparse byte mask.
    issue(1'b1, 32'h10, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 1'b1);
    wait_idle();
    a_rd = n_rd;
    a_wr = n_wr;
    issue(1'b1, 32'h10, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0, 1'b1);
    measure_lat("latency_rmw", 4);
    wait_idle();
    check("rmw_reads", 64'(n_rd - a_rd), 64'(1));
    check("rmw_writes", 64'(n_wr - a_wr), 64'(1));
    check("rmw_order", 64'(seq[1:0]), 64'(2'b10));
    check("rmw_wr_data", 64'(last_wr_data), 64'(32'h11BB_33DD));
    issue(1'b0, 32'h10, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, 1'b1);
    wait_idle();

    // Reset while an RMW sits in CAP: response dropped, word untouched.
    issue(1'b1, 32'h1C, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b1);
    wait_idle();
    a_wr = n_wr;
    issue(1'b1, 32'h1C, 32'h1234_5678, 4'h3, 32'h0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b0;
    #1;
    check("midrst_csb0", 64'(sram_csb0), 64'(1));
    check("midrst_web0", 64'(sram_web0), 64'(1));
    check("midrst_addr0", 64'(sram_addr0), 64'(0));
    check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("midrst_req_ready", 64'(req_ready), 64'(1));
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("midrst_no_write", 64'(n_wr - a_wr), 64'(0));
    check("midrst_mem7", 64'(mem[7]), 64'(32'hCAFE_F00D));
    issue(1'b0, 32'h1C, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
    wait_idle();

    // Random back-to-back traffic against a reference memory, random rsp_ready.
    for (int i = 0; i < 8; i++) begin
      refm[i] = $urandom;
      issue(1'b1, 32'(i * 4), refm[i], 4'hF, 32'h0, 1'b0, 1'b1);
    end
    wait_idle();
    rdy_mode = 2;
    for (int i = 0; i < 20; i++) begin
      int            idx;
      logic          we;
      logic [MW-1:0] m;
      logic [DW-1:0] d;
      int            pick;
      idx  = $urandom_range(0, 7);
      we   = 1'($urandom_range(0, 1));
      d    = $urandom;
      pick = $urandom_range(0, 3);
      m    = (pick == 0) ? 4'h0 : (pick == 1) ? 4'hF : 4'($urandom_range(1, 14));
      if ($urandom_range(0, 9) == 0) begin
        issue(we, 32'(idx * 4 + 2), d, m, 32'h0, 1'b1, 1'b1);
      end else if (we) begin
        refm[idx] = tb_merge(refm[idx], d, m);
        issue(1'b1, 32'(idx * 4), d, m, 32'h0, 1'b0, 1'b1);
      end else begin
        issue(1'b0, 32'(idx * 4), d, m, refm[idx], 1'b0, 1'b1);
      end
    end
    wait_idle();
    rdy_mode = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("final_mem_%0d", i), 64'(mem[i]), 64'(refm[i]));
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    check("csb0_spacing", 64'(viol), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Bus-side controller placed directly upstream of the single-port RW SRAM macro (csb0/web0/addr0/din0/dout0).
- Accepts one valid/ready word request at a time, drives SRAM pins from registers, and captures read data one cycle after the SRAM clock edge.
- Implements byte-masked writes as read-modify-write, because the macro has no byte enables.
- Returns one response per request through a valid/ready response channel.

Parameters:
- ADDR_WIDTH, 7, SRAM word-address width (depth = 2^ADDR_WIDTH words).
- DATA_WIDTH, 32, word width; must be a multiple of 8; MASK_W = DATA_WIDTH/8.

Ports:
- clock  in  1  single clock; also drives SRAM clk0.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  MASK_W  byte enables, bit i = byte i.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  misaligned or out-of-range access.
- sram_csb0  out  1  chip select, active low.
- sram_web0  out  1  write enable, active low.
- sram_addr0  out  ADDR_WIDTH  word address.
- sram_din0  out  DATA_WIDTH  write data.
- sram_dout0  in  DATA_WIDTH  read data.

Behaviour:
- Reset (asynchronous, active-low):
  - State is IDLE.
  - sram_csb0 = 1, sram_web0 = 1, sram_addr0 = 0, sram_din0 = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready = 1 (IDLE).
- Handshakes and registering:
  - All SRAM outputs are flops; there is no combinational path from req_* to sram_*.
  - req_ready = (state == IDLE). At most one request is outstanding.
  - Accept occurs at a clock edge where req_valid && req_ready. At accept, register the word index (req_addr[ADDR_WIDTH+1:2]), wdata, wmask and we.
- Error check at accept:
  - An access is an error if req_addr[1:0] != 0, or if any bit of req_addr[31:ADDR_WIDTH+2] is set.
  - On error, go to RESP with rsp_err = 1 and rsp_rdata = 0. The SRAM is not touched.
- States:
  - IDLE: csb0 = 1.
    - Accepted read, or write with a partial non-zero mask -> RD.
    - Write with full mask -> WR.
    - Write with mask 0 -> RESP with no SRAM access and err = 0.
  - RD: csb0 = 0, web0 = 1, addr0 = index. The SRAM samples at the end of this cycle -> CAP.
  - CAP: csb0 = 1; sram_dout0 is valid during this cycle and is captured at the closing edge.
    - Plain read: rsp_rdata <= dout0 -> RESP.
    - RMW: merged = per byte (wmask[i] ? wdata byte i : dout0 byte i) -> WR.
  - WR: csb0 = 0, web0 = 0, din0 = full wdata or merged word -> RESP. rsp_rdata = 0.
  - RESP: rsp_valid = 1, csb0 = 1. rsp_* stay stable until rsp_ready; on the handshake edge -> IDLE and rsp_valid drops.
- Latency, from accept edge to rsp_valid:
  - read: 3 edges (RD, CAP, RESP).
  - full write: 2 edges.
  - RMW: 4 edges.
  - error or zero-mask write: 1 edge.
- Throughput: no new accept while in RESP. rsp_ready held high gives the IDLE handshake one cycle after the RESP handshake.
- csb0 is low for exactly one cycle per SRAM access: never on back-to-back cycles, and never while in RESP.
- rsp_ready asserted outside RESP is ignored. Request inputs are ignored outside IDLE.
- Reset mid-operation: outputs return to reset values immediately and the in-flight response is discarded.
  - A write already sampled by the SRAM (state after WR) may complete in the array.
  - An RMW interrupted before WR leaves memory unchanged.
- Word-index arithmetic is modulo 2^ADDR_WIDTH by construction, with no wrap logic. Out-of-range is always an error, never aliased.

Decomposition:
- Package sram_ctrl_pkg holds:
  - state enum {IDLE, RD, CAP, WR, RESP};
  - the MASK_W derivation;
  - the function merge_bytes(old, new, mask).
- No sub-module: the FSM and datapath stay in one module, and the SRAM macro is instantiated by the parent.

Test Plan:
1. Write 0xDEADBEEF, mask 0xF, addr 0x10. Then read addr 0x10. Expected:
   - exactly one csb0 = 0/web0 = 0 cycle with addr0 = 4;
   - read returns 0xDEADBEEF with err = 0;
   - rsp_valid 3 edges after the read accept.
2. Preload word 4 = 0x11223344. Write 0xAABBCCDD, mask 0x5. Read back. Expected:
   - one read pulse followed by one write pulse;
   - stored word is 0x11BB33DD.
3. Read addr 0x202 (misaligned), then read addr 0x200 (index 128 when ADDR_WIDTH = 7). Expected:
   - both give err = 1 and rdata = 0;
   - csb0 never asserts.
4. Hold rsp_ready = 0 for 5 cycles after a read response. Expected:
   - rsp_valid and rsp_rdata are stable;
   - req_ready = 0 throughout;
   - a req_valid pulse during that time is not accepted.
5. Assert reset_n low in CAP of an RMW to word 7. Expected:
   - csb0 goes to 1 asynchronously and rsp_valid = 0;
   - word 7 is unchanged on a later read.
6. Send 20 back-to-back random reads and writes with rsp_ready random. Expected:
   - the scoreboard matches a reference memory;
   - no two consecutive cycles have csb0 = 0.
